// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared types for the multicycle core control unit.
// Holds the FSM state enum, opcode map, datapath select encodings and opcode-class helpers.
// Contents: state_e, OP_* opcodes, alu_op_e, pc_src_e, func_e, ctl_t control bundle.
package mc_ctrl_pkg;

  localparam int OPCODE_W = 4;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_e;

  localparam logic [OPCODE_W-1:0] OP_ADD  = 4'd0;
  localparam logic [OPCODE_W-1:0] OP_SUB  = 4'd1;
  localparam logic [OPCODE_W-1:0] OP_AND  = 4'd2;
  localparam logic [OPCODE_W-1:0] OP_OR   = 4'd3;
  localparam logic [OPCODE_W-1:0] OP_ADDI = 4'd4;
  localparam logic [OPCODE_W-1:0] OP_ANDI = 4'd5;
  localparam logic [OPCODE_W-1:0] OP_LW   = 4'd6;
  localparam logic [OPCODE_W-1:0] OP_SW   = 4'd7;
  localparam logic [OPCODE_W-1:0] OP_BEQ  = 4'd8;
  localparam logic [OPCODE_W-1:0] OP_J    = 4'd9;
  localparam logic [OPCODE_W-1:0] OP_CALL = 4'd10;
  localparam logic [OPCODE_W-1:0] OP_RET  = 4'd11;
  localparam logic [OPCODE_W-1:0] OP_HALT = 4'd15;

  typedef enum logic [2:0] {
    ALU_ADD    = 3'd0,
    ALU_SUB    = 3'd1,
    ALU_AND    = 3'd2,
    ALU_OR     = 3'd3,
    ALU_PASS_B = 3'd4
  } alu_op_e;

  typedef enum logic [1:0] {
    PC_PLUS1  = 2'd0,
    PC_BRANCH = 2'd1,
    PC_JUMP   = 2'd2,
    PC_REG    = 2'd3
  } pc_src_e;

  typedef enum logic [1:0] {
    FMT_R = 2'd0,
    FMT_I = 2'd1,
    FMT_J = 2'd2,
    FMT_S = 2'd3
  } func_e;

  // All datapath controls produced by the FSM in one bundle.
  typedef struct packed {
    func_e   func;
    logic    pc_we;
    pc_src_e pc_src;
    logic    ir_we;
    logic    mem_req;
    logic    mem_we;
    logic    addr_sel;
    alu_op_e alu_op;
    logic    alu_src_b;
    logic    reg_we;
    logic    wb_sel;
    logic    halted;
    logic    fault;
  } ctl_t;

  function automatic func_e op_format(input logic [OPCODE_W-1:0] op);
    func_e f;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR:                 f = FMT_R;
      OP_ADDI, OP_ANDI, OP_LW, OP_SW, OP_BEQ:        f = FMT_I;
      OP_J, OP_CALL:                                 f = FMT_J;
      OP_RET:                                        f = FMT_S;
      default:                                       f = FMT_R;
    endcase
    return f;
  endfunction

  function automatic alu_op_e op_alu(input logic [OPCODE_W-1:0] op);
    alu_op_e a;
    case (op)
      OP_SUB, OP_BEQ:  a = ALU_SUB;
      OP_AND, OP_ANDI: a = ALU_AND;
      OP_OR:           a = ALU_OR;
      OP_CALL:         a = ALU_PASS_B;
      default:         a = ALU_ADD;
    endcase
    return a;
  endfunction

  // Immediate operand on ALU port B for I-type ALU and load/store address forms.
  function automatic logic op_imm(input logic [OPCODE_W-1:0] op);
    return (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_LW) || (op == OP_SW);
  endfunction

  // Opcodes 0..11 execute; HALT and every unassigned opcode stop the core.
  function automatic logic op_runs(input logic [OPCODE_W-1:0] op);
    return op <= OP_RET;
  endfunction

endpackage

// File: rtl/multicycle_control_unit_if.sv
// multicycle_control_unit_if: status inputs and control outputs between the FSM and datapath.
// master = control unit (reads opcode/mode/zero/mem_ready, drives all controls);
// slave = datapath/memory side. Purely combinational wiring, no latency, no flow control.
interface multicycle_control_unit_if #(
  parameter int OPW = 4
);
  logic [OPW-1:0] opcode;
  logic           mode;
  logic           zero;
  logic           mem_ready;

  logic [1:0]     func;
  logic           pc_we;
  logic [1:0]     pc_src;
  logic           ir_we;
  logic           mem_req;
  logic           mem_we;
  logic           addr_sel;
  logic [2:0]     alu_op;
  logic           alu_src_b;
  logic           reg_we;
  logic           wb_sel;
  logic           halted;
  logic           fault;

  modport master (
    input  opcode, mode, zero, mem_ready,
    output func, pc_we, pc_src, ir_we, mem_req, mem_we, addr_sel,
           alu_op, alu_src_b, reg_we, wb_sel, halted, fault
  );

  modport slave (
    output opcode, mode, zero, mem_ready,
    input  func, pc_we, pc_src, ir_we, mem_req, mem_we, addr_sel,
           alu_op, alu_src_b, reg_we, wb_sel, halted, fault
  );
endinterface

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: counts cycles a memory request waits for mem_ready; flags expiry.
// Latency: expire is combinational in the cycle the count would reach TMO_LIMIT.
// Backpressure: none; clr has priority over inc. Ports: clk, rst_n, clr, inc, expire.
module mem_wait_timer #(
  parameter int TMO_W     = 4,
  parameter int TMO_LIMIT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic expire
);
  logic [TMO_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + TMO_W'(1);
    end
  end

  // The wait cycle that would make the count equal TMO_LIMIT is the last one allowed.
  assign expire = inc && (cnt_q == TMO_W'(TMO_LIMIT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: FETCH/DECODE/EXEC/MEM/WB sequencer for the multicycle 16-bit core.
// Latency: R/I 4, LW 5, SW 4, branch/jump 3 cycles; FETCH and MEM stall until mem_ready.
// Backpressure: mem_req held until mem_ready. Ports: clk, rst_n, bus (master modport).
// Optional feature macro MEM_TIMEOUT_EN: memory-wait watchdog -> HALT with sticky fault.
module multicycle_control_unit
  import mc_ctrl_pkg::*;
#(
  parameter int OPW       = OPCODE_W,
  parameter int TMO_W     = 4,
  parameter int TMO_LIMIT = 15
) (
  input  logic                      clk,
  input  logic                      rst_n,
  multicycle_control_unit_if.master bus
);
  state_e         state_q, state_d, state_nxt;
  logic [OPW-1:0] op_q, op_d;
  ctl_t           ctl, ctl_o;
  logic           fault_q;

  // Next state and Moore controls. DECODE looks at the live IR field (just loaded);
  // later states use the opcode captured at DECODE.
  always_comb begin
    state_nxt = state_q;
    op_d      = op_q;
    ctl       = '0;
    ctl.fault = fault_q;

    case (state_q)
      ST_FETCH: begin
        ctl.mem_req  = 1'b1;
        ctl.addr_sel = 1'b0;
        if (bus.mem_ready) begin
          ctl.ir_we  = 1'b1;
          ctl.pc_we  = 1'b1;
          ctl.pc_src = PC_PLUS1;
          state_nxt  = ST_DECODE;
        end
      end

      ST_DECODE: begin
        op_d      = bus.opcode;
        ctl.func  = op_format(bus.opcode);
        state_nxt = op_runs(bus.opcode) ? ST_EXEC : ST_HALT;
      end

      ST_EXEC: begin
        ctl.func      = op_format(op_q);
        ctl.alu_op    = op_alu(op_q);
        ctl.alu_src_b = op_imm(op_q);
        state_nxt     = ST_FETCH;
        case (op_q)
          OP_LW, OP_SW: state_nxt = ST_MEM;
          OP_BEQ: begin
            // mode turns BEQ into BNE.
            ctl.pc_we  = bus.zero ^ bus.mode;
            ctl.pc_src = PC_BRANCH;
          end
          OP_J: begin
            ctl.pc_we  = 1'b1;
            ctl.pc_src = PC_JUMP;
          end
          OP_CALL: begin
            // Link: R7 <- PASS_B of the already-incremented PC, same cycle as the jump.
            ctl.pc_we  = 1'b1;
            ctl.pc_src = PC_JUMP;
            ctl.reg_we = 1'b1;
          end
          OP_RET: begin
            ctl.pc_we  = 1'b1;
            ctl.pc_src = PC_REG;
          end
          default: state_nxt = ST_WB;
        endcase
      end

      ST_MEM: begin
        // Keep the address computation driven while the access is outstanding.
        ctl.func      = op_format(op_q);
        ctl.alu_op    = op_alu(op_q);
        ctl.alu_src_b = op_imm(op_q);
        ctl.mem_req   = 1'b1;
        ctl.addr_sel  = 1'b1;
        ctl.mem_we    = (op_q == OP_SW);
        if (bus.mem_ready) begin
          state_nxt = (op_q == OP_SW) ? ST_FETCH : ST_WB;
        end
      end

      ST_WB: begin
        ctl.func      = op_format(op_q);
        ctl.alu_op    = op_alu(op_q);
        ctl.alu_src_b = op_imm(op_q);
        ctl.reg_we    = 1'b1;
        ctl.wb_sel    = (op_q == OP_LW);
        state_nxt     = ST_FETCH;
      end

      ST_HALT: begin
        ctl.halted = 1'b1;
      end

      default: state_nxt = ST_FETCH;
    endcase
  end

`ifdef MEM_TIMEOUT_EN
  logic tmo_inc, tmo_clr, tmo_expire, fault_d;

  assign tmo_inc = ctl.mem_req & ~bus.mem_ready;
  // Any state change clears the count, so it starts at zero on entry to FETCH or MEM.
  assign tmo_clr = (state_d != state_q);

  mem_wait_timer #(
    .TMO_W     (TMO_W),
    .TMO_LIMIT (TMO_LIMIT)
  ) u_mem_wait_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (tmo_clr),
    .inc    (tmo_inc),
    .expire (tmo_expire)
  );

  always_comb begin
    state_d = state_nxt;
    fault_d = fault_q;
    if (tmo_expire) begin
      state_d = ST_HALT;
      fault_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_d;
    end
  end
`else
  logic unused_tmo_cfg;

  assign state_d        = state_nxt;
  assign fault_q        = 1'b0;
  assign unused_tmo_cfg = ^{TMO_W[0], TMO_LIMIT[0]};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FETCH;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  // Reset forces every control low at once, so an access or write in flight is dropped
  // immediately rather than at the next edge.
  assign ctl_o = rst_n ? ctl : '0;

  assign bus.func      = ctl_o.func;
  assign bus.pc_we     = ctl_o.pc_we;
  assign bus.pc_src    = ctl_o.pc_src;
  assign bus.ir_we     = ctl_o.ir_we;
  assign bus.mem_req   = ctl_o.mem_req;
  assign bus.mem_we    = ctl_o.mem_we;
  assign bus.addr_sel  = ctl_o.addr_sel;
  assign bus.alu_op    = ctl_o.alu_op;
  assign bus.alu_src_b = ctl_o.alu_src_b;
  assign bus.reg_we    = ctl_o.reg_we;
  assign bus.wb_sel    = ctl_o.wb_sel;
  assign bus.halted    = ctl_o.halted;
  assign bus.fault     = ctl_o.fault;
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: scenario tasks push per-cycle stimulus plus expected controls
// into a queue; each task then drains it, driving inputs on the falling edge and comparing.
// Timeout scenario runs only when MEM_TIMEOUT_EN is defined.
module tb_multicycle_control_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  multicycle_control_unit_if #(.OPW(4)) bus ();

  multicycle_control_unit #(
    .OPW       (4),
    .TMO_W     (4),
    .TMO_LIMIT (15)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [1:0] func;
    logic       pc_we;
    logic [1:0] pc_src;
    logic       ir_we;
    logic       mem_req;
    logic       mem_we;
    logic       addr_sel;
    logic [2:0] alu_op;
    logic       alu_src_b;
    logic       reg_we;
    logic       wb_sel;
    logic       halted;
    logic       fault;
  } obs_t;

  typedef struct {
    bit         mr;
    bit         z;
    bit         md;
    logic [3:0] op;
    obs_t       exp;
    obs_t       msk;
    string      nm;
  } stim_t;

  stim_t sq[$];
  int    n_chk  = 0;
  int    n_pass = 0;

  localparam logic [2:0] A_ADD = 3'd0, A_SUB = 3'd1, A_AND = 3'd2, A_OR = 3'd3, A_PASS = 3'd4;
  localparam logic [2:0] ALU_TAB [6] = '{A_ADD, A_SUB, A_AND, A_OR, A_ADD, A_AND};

  function automatic obs_t sample();
    obs_t o;
    o.func = bus.func;       o.pc_we = bus.pc_we;       o.pc_src = bus.pc_src;
    o.ir_we = bus.ir_we;     o.mem_req = bus.mem_req;   o.mem_we = bus.mem_we;
    o.addr_sel = bus.addr_sel; o.alu_op = bus.alu_op;   o.alu_src_b = bus.alu_src_b;
    o.reg_we = bus.reg_we;   o.wb_sel = bus.wb_sel;     o.halted = bus.halted;
    o.fault = bus.fault;
    return o;
  endfunction

  // Expected-control constructors, one per state as the datapath sees it.
  function automatic obs_t f_fetch(bit mr);
    obs_t c = '0;
    c.mem_req = 1'b1; c.ir_we = mr; c.pc_we = mr; c.pc_src = 2'b00;
    return c;
  endfunction
  function automatic obs_t f_dec(logic [1:0] fn);
    obs_t c = '0;
    c.func = fn;
    return c;
  endfunction
  function automatic obs_t f_exec(logic [2:0] a, bit b);
    obs_t c = '0;
    c.alu_op = a; c.alu_src_b = b;
    return c;
  endfunction
  function automatic obs_t f_mem(bit we);
    obs_t c = '0;
    c.mem_req = 1'b1; c.addr_sel = 1'b1; c.mem_we = we;
    return c;
  endfunction
  function automatic obs_t f_wb(bit sel);
    obs_t c = '0;
    c.reg_we = 1'b1; c.wb_sel = sel;
    return c;
  endfunction
  function automatic obs_t f_halt(bit f);
    obs_t c = '0;
    c.halted = 1'b1; c.fault = f;
    return c;
  endfunction

  // Fields that carry no meaning in a given cycle (e.g. pc_src with pc_we low) are masked.
  function automatic void push(bit mr, bit z, bit md, logic [3:0] op, obs_t e,
                               bit cf, bit ca, bit cb, string nm);
    stim_t s;
    obs_t  m = '1;
    if (!cf) m.func = '0;
    if (!ca) m.alu_op = '0;
    if (!cb) m.alu_src_b = 1'b0;
    if (!e.pc_we) m.pc_src = '0;
    if (!e.mem_req) m.addr_sel = 1'b0;
    if (!e.reg_we) m.wb_sel = 1'b0;
    s.mr = mr; s.z = z; s.md = md; s.op = op; s.exp = e; s.msk = m; s.nm = nm;
    sq.push_back(s);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.mem_ready = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    obs_t got;
    stim_t s;
    bus.mem_ready = 1'b1; bus.zero = 1'b0; bus.mode = 1'b0; bus.opcode = 4'd0;
    #2;
    got = sample();
    n_chk++;
    if (got !== '0) $display("FAIL reset_outputs: got %h expected 0", got);
    else n_pass++;
    @(posedge clk);
    #1 rst_n = 1'b1;
    push(0, 0, 0, 4'd0, f_fetch(0), 0, 0, 0, "reset_fetch_wait0");
    push(0, 0, 0, 4'd0, f_fetch(0), 0, 0, 0, "reset_fetch_wait1");
    while (sq.size() > 0) begin
      s = sq.pop_front();
      @(negedge clk);
      bus.mem_ready = s.mr; bus.zero = s.z; bus.mode = s.md; bus.opcode = s.op;
      #1 got = sample();
      n_chk++;
      if ((got & s.msk) !== (s.exp & s.msk))
        $display("FAIL %s: got %h expected %h mask %h", s.nm, got, s.exp, s.msk);
      else n_pass++;
    end
  endtask

  task automatic test_alu();
    obs_t got;
    stim_t s;
    for (int i = 0; i < 6; i++) begin
      push(1, 0, 0, 4'(i), f_fetch(1), 0, 0, 0, $sformatf("alu%0d_fetch", i));
      push(1, 0, 0, 4'(i), f_dec(i < 4 ? 2'b00 : 2'b01), 1, 0, 0, $sformatf("alu%0d_decode", i));
      push(1, 0, 0, 4'(i), f_exec(ALU_TAB[i], i >= 4), 0, 1, 1, $sformatf("alu%0d_exec", i));
      push(1, 0, 0, 4'(i), f_wb(0), 0, 0, 0, $sformatf("alu%0d_wb", i));
    end
    while (sq.size() > 0) begin
      s = sq.pop_front();
      @(negedge clk);
      bus.mem_ready = s.mr; bus.zero = s.z; bus.mode = s.md; bus.opcode = s.op;
      #1 got = sample();
      n_chk++;
      if ((got & s.msk) !== (s.exp & s.msk))
        $display("FAIL %s: got %h expected %h mask %h", s.nm, got, s.exp, s.msk);
      else n_pass++;
    end
  endtask

  task automatic test_load_store();
    obs_t got;
    stim_t s;
    // LW with three wait cycles in MEM: eight cycles end to end.
    push(1, 0, 0, 4'd6, f_fetch(1), 0, 0, 0, "lw_fetch");
    push(1, 0, 0, 4'd6, f_dec(2'b01), 1, 0, 0, "lw_decode");
    push(1, 0, 0, 4'd6, f_exec(A_ADD, 1), 0, 1, 1, "lw_exec");
    for (int i = 0; i < 3; i++) push(0, 0, 0, 4'd6, f_mem(0), 0, 0, 0, $sformatf("lw_mem_wait%0d", i));
    push(1, 0, 0, 4'd6, f_mem(0), 0, 0, 0, "lw_mem_done");
    push(1, 0, 0, 4'd6, f_wb(1), 0, 0, 0, "lw_wb");
    // SW with no wait returns to FETCH after MEM.
    push(1, 0, 0, 4'd7, f_fetch(1), 0, 0, 0, "sw_fetch");
    push(1, 0, 0, 4'd7, f_dec(2'b01), 1, 0, 0, "sw_decode");
    push(1, 0, 0, 4'd7, f_exec(A_ADD, 1), 0, 1, 1, "sw_exec");
    push(1, 0, 0, 4'd7, f_mem(1), 0, 0, 0, "sw_mem");
    push(0, 0, 0, 4'd7, f_fetch(0), 0, 0, 0, "sw_next_fetch");
    while (sq.size() > 0) begin
      s = sq.pop_front();
      @(negedge clk);
      bus.mem_ready = s.mr; bus.zero = s.z; bus.mode = s.md; bus.opcode = s.op;
      #1 got = sample();
      n_chk++;
      if ((got & s.msk) !== (s.exp & s.msk))
        $display("FAIL %s: got %h expected %h mask %h", s.nm, got, s.exp, s.msk);
      else n_pass++;
    end
  endtask

  task automatic test_branch();
    obs_t got, e;
    stim_t s;
    bit zt [4] = '{1, 1, 0, 0};
    bit mt [4] = '{0, 1, 1, 0};
    for (int i = 0; i < 4; i++) begin
      e = f_exec(A_SUB, 0);
      e.pc_we = zt[i] ^ mt[i];
      e.pc_src = 2'b01;
      push(1, 0, 0, 4'd8, f_fetch(1), 0, 0, 0, $sformatf("br%0d_fetch", i));
      push(1, 0, 0, 4'd8, f_dec(2'b01), 1, 0, 0, $sformatf("br%0d_decode", i));
      push(1, zt[i], mt[i], 4'd8, e, 0, 1, 1, $sformatf("br%0d_z%0d_m%0d_exec", i, zt[i], mt[i]));
    end
    e = '0; e.pc_we = 1'b1; e.pc_src = 2'b10;
    push(1, 0, 0, 4'd9, f_fetch(1), 0, 0, 0, "j_fetch");
    push(1, 0, 0, 4'd9, f_dec(2'b10), 1, 0, 0, "j_decode");
    push(1, 0, 0, 4'd9, e, 0, 0, 0, "j_exec");
    while (sq.size() > 0) begin
      s = sq.pop_front();
      @(negedge clk);
      bus.mem_ready = s.mr; bus.zero = s.z; bus.mode = s.md; bus.opcode = s.op;
      #1 got = sample();
      n_chk++;
      if ((got & s.msk) !== (s.exp & s.msk))
        $display("FAIL %s: got %h expected %h mask %h", s.nm, got, s.exp, s.msk);
      else n_pass++;
    end
  endtask

  task automatic test_call_ret();
    obs_t got, e;
    stim_t s;
    e = f_exec(A_PASS, 0); e.pc_we = 1'b1; e.pc_src = 2'b10; e.reg_we = 1'b1; e.wb_sel = 1'b0;
    push(1, 0, 0, 4'd10, f_fetch(1), 0, 0, 0, "call_fetch");
    push(1, 0, 0, 4'd10, f_dec(2'b10), 1, 0, 0, "call_decode");
    push(1, 0, 0, 4'd10, e, 0, 1, 0, "call_exec");
    e = '0; e.pc_we = 1'b1; e.pc_src = 2'b11;
    push(1, 0, 0, 4'd11, f_fetch(1), 0, 0, 0, "ret_fetch");
    push(1, 0, 0, 4'd11, f_dec(2'b11), 1, 0, 0, "ret_decode");
    push(1, 0, 0, 4'd11, e, 0, 0, 0, "ret_exec");
    push(0, 0, 0, 4'd11, f_fetch(0), 0, 0, 0, "ret_next_fetch");
    while (sq.size() > 0) begin
      s = sq.pop_front();
      @(negedge clk);
      bus.mem_ready = s.mr; bus.zero = s.z; bus.mode = s.md; bus.opcode = s.op;
      #1 got = sample();
      n_chk++;
      if ((got & s.msk) !== (s.exp & s.msk))
        $display("FAIL %s: got %h expected %h mask %h", s.nm, got, s.exp, s.msk);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_sw();
    obs_t got;
    stim_t s;
    push(1, 0, 0, 4'd7, f_fetch(1), 0, 0, 0, "rsw_fetch");
    push(1, 0, 0, 4'd7, f_dec(2'b01), 1, 0, 0, "rsw_decode");
    push(1, 0, 0, 4'd7, f_exec(A_ADD, 1), 0, 1, 1, "rsw_exec");
    push(0, 0, 0, 4'd7, f_mem(1), 0, 0, 0, "rsw_mem_wait0");
    push(0, 0, 0, 4'd7, f_mem(1), 0, 0, 0, "rsw_mem_wait1");
    while (sq.size() > 0) begin
      s = sq.pop_front();
      @(negedge clk);
      bus.mem_ready = s.mr; bus.zero = s.z; bus.mode = s.md; bus.opcode = s.op;
      #1 got = sample();
      n_chk++;
      if ((got & s.msk) !== (s.exp & s.msk))
        $display("FAIL %s: got %h expected %h mask %h", s.nm, got, s.exp, s.msk);
      else n_pass++;
    end
    // Assert reset between clock edges while the store is still waiting.
    #2 rst_n = 1'b0;
    #1 got = sample();
    n_chk++;
    if (got !== '0) $display("FAIL rsw_async_reset: got %h expected 0", got);
    else n_pass++;
    bus.mem_ready = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    push(0, 0, 0, 4'd0, f_fetch(0), 0, 0, 0, "rsw_restart_wait");
    push(1, 0, 0, 4'd0, f_fetch(1), 0, 0, 0, "rsw_restart_fetch");
    push(1, 0, 0, 4'd0, f_dec(2'b00), 1, 0, 0, "rsw_add_decode");
    push(1, 0, 0, 4'd0, f_exec(A_ADD, 0), 0, 1, 1, "rsw_add_exec");
    push(1, 0, 0, 4'd0, f_wb(0), 0, 0, 0, "rsw_add_wb");
    push(0, 0, 0, 4'd0, f_fetch(0), 0, 0, 0, "rsw_add_next_fetch");
    while (sq.size() > 0) begin
      s = sq.pop_front();
      @(negedge clk);
      bus.mem_ready = s.mr; bus.zero = s.z; bus.mode = s.md; bus.opcode = s.op;
      #1 got = sample();
      n_chk++;
      if ((got & s.msk) !== (s.exp & s.msk))
        $display("FAIL %s: got %h expected %h mask %h", s.nm, got, s.exp, s.msk);
      else n_pass++;
    end
  endtask

  task automatic test_halt();
    obs_t got;
    stim_t s;
    logic [3:0] hop [2] = '{4'd15, 4'd13};
    for (int k = 0; k < 2; k++) begin
      push(1, 0, 0, hop[k], f_fetch(1), 0, 0, 0, $sformatf("halt_op%0d_fetch", hop[k]));
      push(1, 0, 0, hop[k], f_dec(2'b00), 0, 0, 0, $sformatf("halt_op%0d_decode", hop[k]));
      for (int i = 0; i < 3; i++)
        push(1, 0, 0, hop[k], f_halt(0), 0, 0, 0, $sformatf("halt_op%0d_stay%0d", hop[k], i));
      while (sq.size() > 0) begin
        s = sq.pop_front();
        @(negedge clk);
        bus.mem_ready = s.mr; bus.zero = s.z; bus.mode = s.md; bus.opcode = s.op;
        #1 got = sample();
        n_chk++;
        if ((got & s.msk) !== (s.exp & s.msk))
          $display("FAIL %s: got %h expected %h mask %h", s.nm, got, s.exp, s.msk);
        else n_pass++;
      end
      do_reset();
    end
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout();
    obs_t got;
    stim_t s;
    for (int i = 0; i < 15; i++) push(0, 0, 0, 4'd0, f_fetch(0), 0, 0, 0, $sformatf("tmo_wait%0d", i));
    push(0, 0, 0, 4'd0, f_halt(1), 0, 0, 0, "tmo_halt_fault");
    push(1, 0, 0, 4'd0, f_halt(1), 0, 0, 0, "tmo_fault_sticky");
    while (sq.size() > 0) begin
      s = sq.pop_front();
      @(negedge clk);
      bus.mem_ready = s.mr; bus.zero = s.z; bus.mode = s.md; bus.opcode = s.op;
      #1 got = sample();
      n_chk++;
      if ((got & s.msk) !== (s.exp & s.msk))
        $display("FAIL %s: got %h expected %h mask %h", s.nm, got, s.exp, s.msk);
      else n_pass++;
    end
    do_reset();
    push(0, 0, 0, 4'd0, f_fetch(0), 0, 0, 0, "tmo_fault_cleared");
    while (sq.size() > 0) begin
      s = sq.pop_front();
      @(negedge clk);
      bus.mem_ready = s.mr; bus.zero = s.z; bus.mode = s.md; bus.opcode = s.op;
      #1 got = sample();
      n_chk++;
      if ((got & s.msk) !== (s.exp & s.msk))
        $display("FAIL %s: got %h expected %h mask %h", s.nm, got, s.exp, s.msk);
      else n_pass++;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_alu();
    test_load_store();
    test_branch();
    test_call_ret();
    test_reset_mid_sw();
    test_halt();
`ifdef MEM_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
